// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and scheduler state encodings.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    localparam logic [2:0] SCH_IDLE      = 3'd0;
    localparam logic [2:0] SCH_LOAD      = 3'd1;
    localparam logic [2:0] SCH_WAIT_BUSY = 3'd2;
    localparam logic [2:0] SCH_WAIT_DONE = 3'd3;
    localparam logic [2:0] SCH_GAP       = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = SCH_IDLE,
        ST_LOAD      = SCH_LOAD,
        ST_WAIT_BUSY = SCH_WAIT_BUSY,
        ST_WAIT_DONE = SCH_WAIT_DONE,
        ST_GAP       = SCH_GAP
    } sch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                gnt[pos[IW-1:0]]   = 1'b1;
                gnt_idx            = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding bytes from NUM_REQ producers into a single UART transmitter.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         tx_p_data,
    output logic                           tx_data_valid,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           frame_done,
    output logic                           err_no_start
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned TO_W     = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TO_LAST  = START_TIMEOUT - 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sch_state_t             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [TO_W-1:0]        to_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [IDX_W-1:0]       next_ptr;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // The last winner drops to lowest priority for the next round.
    assign next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            req_ready     <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            frame_done    <= 1'b0;
            err_no_start  <= 1'b0;
        end else begin
            req_ready     <= '0;
            tx_data_valid <= 1'b0;
            frame_done    <= 1'b0;
            err_no_start  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any && !tx_busy) begin
                        tx_p_data <= req_bytes[arb_idx];
                        grant_id  <= arb_idx;
                        req_ready <= arb_gnt;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_valid <= 1'b1;
                    to_cnt        <= '0;
                    state         <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_W'(TO_LAST)) begin
                        // Transmitter never started: the byte is dropped.
                        err_no_start <= 1'b1;
                        rr_ptr       <= next_ptr;
                        state        <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        rr_ptr     <= next_ptr;
                        gap_cnt    <= '0;
                        state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized frames against a round-robin reference model.
module tb_uart_tx_scheduler;

    localparam int GAP = 1;
    localparam int ST  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rv = '0;
    logic [7:0]  rd [4];
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic        err_no_start;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int exp_ptr = 0;
    int last_end_cyc = 0;
    bit last_end_valid = 0;
    bit last_was_err = 0;

    // Behavioural UART transmitter
    bit ext_busy = 0;
    bit no_start = 0;
    int busy_delay = 2;
    int busy_len = 5;
    logic fb = 1'b0;
    int pend = 0;
    int blen = 0;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};
    assign tx_busy  = fb | ext_busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(GAP), .START_TIMEOUT(ST)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (rv),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .frame_done    (frame_done),
        .err_no_start  (err_no_start)
    );

    // Transmitter keeps running across scheduler reset, like a real UART.
    always @(posedge clk) begin
        if (tx_data_valid && !no_start) begin
            if (busy_delay <= 1) begin
                fb   <= 1'b1;
                blen <= busy_len;
            end else begin
                pend <= busy_delay - 1;
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                fb   <= 1'b1;
                blen <= busy_len;
            end
        end else if (fb) begin
            if (blen <= 1) fb <= 1'b0;
            else blen <= blen - 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rv  = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        last_end_valid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_pdata"}, 32'(tx_p_data), 0);
        check({tag, "_dv"}, 32'(tx_data_valid), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(err_no_start), 0);
    endtask

    // One full transaction: grant, Data_Valid, then frame_done or timeout.
    // refill: 0 hold request, 1 drop it, 2 randomize the requester afterwards.
    task automatic do_frame(input int exp_w, input bit to_exp, input int refill);
        int n;
        int fall_cyc;
        bit seen_busy;
        logic [7:0] d;
        int j;
        n = 0;
        while (req_ready == '0 && n < 100) begin
            tick();
            n++;
        end
        check("grant_seen", 32'(req_ready != '0), 1);
        if (last_end_valid)
            check("arb_gap", 32'(cyc - last_end_cyc), last_was_err ? 1 : 32'(GAP + 1));
        check("ready_onehot", 32'(req_ready), 32'd1 << exp_w);
        check("grant_id", 32'(grant_id), 32'(exp_w));
        d = rd[exp_w];
        if (refill == 1) begin
            rv[exp_w] = 1'b0;
        end else if (refill == 2) begin
            rv[exp_w] = 1'($urandom_range(0, 1));
            rd[exp_w] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, 3);
                if (j != exp_w) rv[j] = 1'b0;
            end
            if (rv == '0) rv[$urandom_range(0, 3)] = 1'b1;
        end
        tick();
        check("ready_pulse", 32'(req_ready), 0);
        check("dv_set", 32'(tx_data_valid), 1);
        check("p_data", 32'(tx_p_data), 32'(d));
        tick();
        check("dv_single", 32'(tx_data_valid), 0);
        if (to_exp) begin
            for (int k = 1; k < ST; k++) begin
                check("err_early", 32'(err_no_start), 0);
                tick();
            end
            check("err_pulse", 32'(err_no_start), 1);
            check("no_done_on_err", 32'(frame_done), 0);
            last_was_err = 1;
        end else begin
            seen_busy = 0;
            fall_cyc = -1;
            n = 0;
            while (frame_done !== 1'b1 && n < 200) begin
                if (tx_busy) seen_busy = 1;
                else if (seen_busy && fall_cyc < 0) fall_cyc = cyc;
                tick();
                n++;
            end
            check("done_seen", 32'(frame_done), 1);
            check("done_after_fall", 32'(cyc), 32'(fall_cyc + 1));
            check("no_err", 32'(err_no_start), 0);
            check("p_data_hold", 32'(tx_p_data), 32'(d));
            check("grant_hold", 32'(grant_id), 32'(exp_w));
            last_was_err = 0;
        end
        exp_ptr = (exp_w + 1) % 4;
        last_end_cyc = cyc;
        last_end_valid = (rv != '0);
        tick();
        check("end_single", 32'(frame_done | err_no_start), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) rd[i] = '0;

        // Reset state
        do_reset();
        check_all_zero("rst");

        // Single requester
        rd[0] = 8'hA5;
        rv = 4'b0001;
        busy_delay = 2;
        busy_len = 5;
        do_frame(0, 0, 1);

        // Contention, all held: rotation 0,1,2,3,0
        do_reset();
        rd[0] = 8'h10; rd[1] = 8'h20; rd[2] = 8'h30; rd[3] = 8'h40;
        rv = 4'b1111;
        do_frame(0, 0, 0);
        do_frame(1, 0, 0);
        do_frame(2, 0, 0);
        do_frame(3, 0, 0);
        do_frame(0, 0, 0);

        // Pointer wrap
        do_reset();
        rd[2] = 8'h77;
        rv = 4'b0100;
        do_frame(2, 0, 1);
        rd[0] = 8'h01; rd[3] = 8'h83;
        rv = 4'b1001;
        do_frame(3, 0, 1);
        do_frame(0, 0, 1);
        rv = 4'b1111;
        do_frame(1, 0, 1);

        // Start timeout, then next requester served
        do_reset();
        rd[1] = 8'hC1; rd[2] = 8'hC2;
        rv = 4'b0110;
        no_start = 1;
        do_frame(1, 1, 1);
        no_start = 0;
        do_frame(2, 0, 1);

        // Reset during WAIT_DONE
        do_reset();
        rd[2] = 8'h5C;
        rv = 4'b0100;
        busy_delay = 1;
        busy_len = 12;
        n = 0;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
        check("mf_grant", 32'(req_ready), 32'h4);
        rv[2] = 1'b0;
        n = 0;
        while (!tx_busy && n < 50) begin tick(); n++; end
        tick();
        tick();
        rst = 1'b1;
        rd[3] = 8'hE7;
        rv = 4'b1000;
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        last_end_valid = 0;
        check_all_zero("mf");
        n = 0;
        while (tx_busy && n < 50) begin
            check("mf_hold_ready", 32'(req_ready), 0);
            check("mf_no_done", 32'(frame_done), 0);
            tick();
            n++;
        end
        tick();
        check("mf_grant_after_busy", 32'(req_ready), 32'h8);
        do_frame(rr_pick(exp_ptr, rv), 0, 1);

        // External busy blocks arbitration
        tick(); tick(); tick();
        ext_busy = 1;
        rd[1] = 8'h3C;
        rv = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ext_no_ready", 32'(req_ready), 0);
        end
        ext_busy = 0;
        tick();
        check("ext_grant", 32'(req_ready), 32'h2);
        last_end_valid = 0;
        do_frame(1, 0, 1);

        // Randomized frames against the reference model
        do_reset();
        for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
        rv = 4'($urandom_range(1, 15));
        for (int f = 0; f < 40; f++) begin
            busy_delay = $urandom_range(1, 3);
            busy_len = $urandom_range(1, 6);
            no_start = ($urandom_range(0, 5) == 0);
            do_frame(rr_pick(exp_ptr, rv), no_start, 2);
        end
        no_start = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
